// File: rtl/serial_deserializer.sv
// Framed serial-to-parallel receiver: LSB-first payload followed by an all-ones trailer.
module serial_deserializer #(
    parameter int unsigned WORD_LENGTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   serial_in,
    input  logic                   sync,
    output logic [WORD_LENGTH-1:0] data_out,
    output logic                   valid,
    output logic                   frame_err,
    output logic                   busy
);

    localparam int unsigned W  = WORD_LENGTH;
    localparam int unsigned CW = $clog2(WORD_LENGTH) + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DATA    = 2'd1,
        TRAILER = 2'd2
    } state_t;

    state_t          state, state_next;
    logic [CW-1:0]   cnt, cnt_next;
    logic [W-1:0]    payload, payload_next;
    logic            trl_err, trl_err_next;
    logic [W-1:0]    data_out_next;
    logic            valid_next;
    logic            frame_err_next;
    logic            busy_next;
    logic            bit_err;
    logic            last_bit;

    // State and datapath registers, all cleared asynchronously
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            payload   <= '0;
            trl_err   <= 1'b0;
            data_out  <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            payload   <= payload_next;
            trl_err   <= trl_err_next;
            data_out  <= data_out_next;
            valid     <= valid_next;
            frame_err <= frame_err_next;
            busy      <= busy_next;
        end
    end

    // Next-state and next-output logic; sync always wins and restarts the frame
    always_comb begin
        state_next     = state;
        cnt_next       = cnt;
        payload_next   = payload;
        trl_err_next   = trl_err;
        data_out_next  = data_out;
        valid_next     = 1'b0;
        frame_err_next = 1'b0;
        bit_err        = trl_err | ~serial_in;
        last_bit       = (cnt == CW'(W - 1));

        if (sync) begin
            // A sync inside an unfinished frame kills that frame
            frame_err_next = (state != IDLE);
            state_next     = DATA;
            cnt_next       = CW'(1);
            payload_next   = W'(serial_in);
            trl_err_next   = 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                end
                DATA: begin
                    payload_next = payload | (W'(serial_in) << cnt);
                    if (last_bit) begin
                        cnt_next     = '0;
                        trl_err_next = 1'b0;
                        state_next   = TRAILER;
                    end else begin
                        cnt_next = cnt + CW'(1);
                    end
                end
                TRAILER: begin
                    trl_err_next = bit_err;
                    if (last_bit) begin
                        cnt_next   = '0;
                        state_next = IDLE;
                        if (bit_err) begin
                            frame_err_next = 1'b1;
                        end else begin
                            data_out_next = payload;
                            valid_next    = 1'b1;
                        end
                    end else begin
                        cnt_next = cnt + CW'(1);
                    end
                end
                default: begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            endcase
        end

        // busy spans the frame including its completion-pulse cycle
        busy_next = (state_next != IDLE) | valid_next | frame_err_next;
    end

endmodule

// File: tb/tb_serial_deserializer.sv
// Directed self-checking bench for serial_deserializer (WORD_LENGTH = 8).
module tb_serial_deserializer;

    localparam int unsigned W = 8;

    logic         clk;
    logic         reset;
    logic         serial_in;
    logic         sync;
    logic [W-1:0] data_out;
    logic         valid;
    logic         frame_err;
    logic         busy;

    int vectors     = 0;
    int miscompares = 0;

    serial_deserializer #(.WORD_LENGTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .serial_in (serial_in),
        .sync      (sync),
        .data_out  (data_out),
        .valid     (valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle's inputs, then land 1 time unit after the sampling edge
    task automatic step(input logic s, input logic b);
        @(negedge clk);
        sync      = s;
        serial_in = b;
        @(posedge clk);
        #1;
    endtask

    // Drive n bits of a frame (sync on bit 0); checks outputs of the following cycles
    // except the completion cycle, which the caller checks.
    task automatic drive_frame(input logic [W-1:0] word, input logic [W-1:0] trailer,
                               input int n, input logic first_err);
        logic [2*W-1:0] bits;
        bits = {trailer, word};
        for (int i = 0; i < n; i++) begin
            step(i == 0, bits[i]);
            if (i < 2*W - 1) begin
                chk("frame_valid", 32'(valid), 32'(0));
                chk("frame_err", 32'(frame_err), (i == 0) ? 32'(first_err) : 32'(0));
                chk("frame_busy", 32'(busy), 32'(1));
            end
        end
    endtask

    initial begin
        reset     = 1'b0;
        sync      = 1'b0;
        serial_in = 1'b0;
        #3;
        chk("rst_data", 32'(data_out), 32'h0);
        chk("rst_valid", 32'(valid), 32'(0));
        chk("rst_err", 32'(frame_err), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        @(negedge clk);
        reset = 1'b1;
        step(1'b0, 1'b1);
        chk("idle_busy", 32'(busy), 32'(0));

        // Good frame 0xA5: valid and data in cycle 16 only, busy through cycle 16
        drive_frame(8'hA5, 8'hFF, 16, 1'b0);
        chk("good_valid", 32'(valid), 32'(1));
        chk("good_err", 32'(frame_err), 32'(0));
        chk("good_data", 32'(data_out), 32'hA5);
        chk("good_busy16", 32'(busy), 32'(1));
        step(1'b0, 1'b0);
        chk("good_valid17", 32'(valid), 32'(0));
        chk("good_busy17", 32'(busy), 32'(0));

        // Trailer bit 5 is zero: frame_err, data_out keeps 0xA5
        drive_frame(8'h3C, 8'b1101_1111, 16, 1'b0);
        chk("terr_err", 32'(frame_err), 32'(1));
        chk("terr_valid", 32'(valid), 32'(0));
        chk("terr_data", 32'(data_out), 32'hA5);

        // Abort: sync at cycle 0 and again at cycle 5, then good 0x81
        drive_frame(8'hFF, 8'hFF, 5, 1'b0);
        drive_frame(8'h81, 8'hFF, 16, 1'b1);
        chk("abort_valid", 32'(valid), 32'(1));
        chk("abort_err", 32'(frame_err), 32'(0));
        chk("abort_data", 32'(data_out), 32'h81);

        // Back-to-back 0x01 then 0xFE; sync lands in the previous valid cycle
        drive_frame(8'h01, 8'hFF, 16, 1'b0);
        chk("b2b_valid1", 32'(valid), 32'(1));
        chk("b2b_data1", 32'(data_out), 32'h01);
        chk("b2b_busy1", 32'(busy), 32'(1));
        drive_frame(8'hFE, 8'hFF, 16, 1'b0);
        chk("b2b_valid2", 32'(valid), 32'(1));
        chk("b2b_data2", 32'(data_out), 32'hFE);
        chk("b2b_busy2", 32'(busy), 32'(1));

        // Sync on the last trailer cycle aborts the old frame
        drive_frame(8'h55, 8'hFF, 15, 1'b0);
        drive_frame(8'h66, 8'hFF, 16, 1'b1);
        chk("last_valid", 32'(valid), 32'(1));
        chk("last_data", 32'(data_out), 32'h66);
        step(1'b0, 1'b1);
        chk("last_idle_busy", 32'(busy), 32'(0));

        // Reset at cycle 7 of a frame clears everything asynchronously
        drive_frame(8'h77, 8'hFF, 7, 1'b0);
        reset = 1'b0;
        #1;
        chk("mrst_data", 32'(data_out), 32'h0);
        chk("mrst_valid", 32'(valid), 32'(0));
        chk("mrst_err", 32'(frame_err), 32'(0));
        chk("mrst_busy", 32'(busy), 32'(0));
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // No sync: 40 cycles of toggling serial_in, nothing may happen
        for (int i = 0; i < 40; i++) begin
            step(1'b0, i[0]);
            chk("noise_valid", 32'(valid), 32'(0));
            chk("noise_err", 32'(frame_err), 32'(0));
            chk("noise_busy", 32'(busy), 32'(0));
            chk("noise_data", 32'(data_out), 32'h0);
        end

        // Reception resumes at the next sync
        drive_frame(8'hC3, 8'hFF, 16, 1'b0);
        chk("resume_valid", 32'(valid), 32'(1));
        chk("resume_data", 32'(data_out), 32'hC3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/serial_deserializer.md
SERIAL_DESERIALIZER -- requirements
Module: serial_deserializer

Interface
REQ-001 SHALL provide parameter: WORD_LENGTH, 8, number of payload bits per frame (>=2).
REQ-002 SHALL provide port: clk  input  1  rising-edge clock.
REQ-003 SHALL provide port: reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL provide port: serial_in  input  1  serial frame bit, sampled every rising clk edge.
REQ-005 SHALL provide port: sync  input  1  high marks the cycle carrying payload bit 0 of a new frame.
REQ-006 SHALL provide port: data_out  output  WORD_LENGTH  last correctly framed payload word.
REQ-007 SHALL provide port: valid  output  1  one-cycle pulse, data_out just updated.
REQ-008 SHALL provide port: frame_err  output  1  one-cycle pulse, frame rejected.
REQ-009 SHALL provide port: busy  output  1  high while a frame is in progress.

Function
REQ-010 SHALL receive frames of 2*WORD_LENGTH bits: WORD_LENGTH payload bits, LSB first, then WORD_LENGTH trailer bits that must all be 1.
REQ-011 SHALL implement states IDLE, DATA, TRAILER; all outputs registered.
REQ-012 SHALL, in any state, on an edge with sync=1, capture serial_in as payload bit 0, clear the bit counter to 1, and enter DATA.
REQ-013 SHALL, in IDLE with sync=0, ignore serial_in and remain in IDLE.
REQ-014 SHALL, in DATA, shift serial_in into payload bit position equal to the counter; after bit WORD_LENGTH-1, clear the counter and enter TRAILER.
REQ-015 SHALL, in TRAILER, record a sticky trailer-error flag whenever a sampled bit is 0; after trailer bit WORD_LENGTH-1, return to IDLE.
REQ-016 SHALL, on the edge sampling the last trailer bit with no trailer error (this bit included), load data_out with the payload and assert valid for exactly one cycle.
REQ-017 SHALL, on that same edge with a trailer error, assert frame_err for one cycle, leave data_out unchanged, and not assert valid.
REQ-018 SHALL give latency: sync cycle = cycle 0; valid/frame_err high in cycle 2*WORD_LENGTH.
REQ-019 SHALL, on sync=1 while in DATA or TRAILER, abort the current frame, pulse frame_err in the following cycle, and start the new frame per REQ-012.
REQ-020 SHALL let sync=1 on the last trailer-bit cycle take priority: the old frame is aborted (frame_err, no valid) and a new frame starts.
REQ-021 SHALL never assert valid and frame_err in the same cycle.
REQ-022 SHALL hold busy=1 in DATA and TRAILER and busy=0 in IDLE; busy stays 1 across back-to-back frames.
REQ-023 SHALL accept back-to-back frames: sync in cycle 2*WORD_LENGTH after the previous sync is legal and loses no bits.
REQ-024 SHALL size the bit counter to ceil(log2(WORD_LENGTH))+1 bits, with no wrap-around before the state transition.

Reset
REQ-025 SHALL, on reset=0, asynchronously force state IDLE, counter 0, payload 0, trailer-error flag 0, data_out 0, valid 0, frame_err 0 and busy 0.
REQ-026 SHALL, on reset mid-frame, discard the partial frame with no valid or frame_err pulse; reception resumes only at the next sync after reset release.

Verification (WORD_LENGTH=8)
REQ-027 SHALL cover a good frame: sync at cycle 0, serial bits of 0xA5 LSB first, then 8 ones -> data_out=0xA5, valid=1 in cycle 16 only, busy=1 in cycles 1..16.
REQ-028 SHALL cover a trailer error: frame 0x3C with trailer bit 5 = 0 -> frame_err=1 in cycle 16, valid=0, data_out keeps its previous value.
REQ-029 SHALL cover abort: sync at cycle 0, second sync at cycle 5 followed by a good frame 0x81 -> frame_err=1 in cycle 6, valid=1 with data_out=0x81 in cycle 21.
REQ-030 SHALL cover back-to-back: frames 0x01 and 0xFE with syncs at cycles 0 and 16 -> valid in cycles 16 and 32 with data_out 0x01 and then 0xFE; busy never drops.
REQ-031 SHALL cover reset mid-frame: reset=0 at cycle 7 of a frame, released, no sync -> all outputs 0, no pulses, state IDLE.
REQ-032 SHALL cover noise in IDLE: serial_in toggling with sync=0 for 40 cycles -> busy, valid, frame_err all remain 0.
